serial_tx: RTL and testbench



---
 rtl/serial_tx.sv | 88 ++++++++
 tb/tb_serial_tx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: framed parallel-to-serial transmitter (start, DATA_W bits LSB first, optional even parity, stop).
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic par, par_n, last;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        last    = cnt == CNT_LAST;
        if (state == IDLE) begin
            if (tx_valid && tx_ready) begin
                state_n = START;
                shift_n = tx_data;
                par_n   = ^tx_data;
                cnt_n   = '0;
            end
        end else begin
            cnt_n = last ? '0 : cnt + 1'b1;
            if (last) begin
                case (state)
                    START: begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                    DATA: begin
                        shift_n = shift >> 1;
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) state_n = PARITY_EN ? PARITY : STOP;
                    end
                    PARITY:  state_n = STOP;
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // Outputs are decoded from the next state so that they register alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par      <= par_n;
            tx_out   <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] :
                        state_n == PARITY ? par_n : 1'b1;
            tx_ready <= state_n == IDLE;
            tx_busy  <= state_n != IDLE;
            tx_done  <= state == STOP && state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: three configurations of serial_tx checked cycle by cycle against a frame-level line model.
module tb_serial_tx;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] data [3];
    logic [2:0] valid, out, ready, busy, done;
    int dw [3]  = '{8, 8, 1};
    int cpb [3] = '{4, 4, 1};
    int pe [3]  = '{0, 1, 0};
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u2 (
        .clk(clk), .reset(reset), .tx_data(data[2][0:0]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input int s, input string tag);
        check({tag, "_out"}, 32'(out[s]), 1);
        check({tag, "_ready"}, 32'(ready[s]), 1);
        check({tag, "_busy"}, 32'(busy[s]), 0);
        check({tag, "_done"}, 32'(done[s]), 0);
    endtask

    task automatic start(input int s, input logic [7:0] d);
        @(negedge clk);
        data[s]  = d;
        valid[s] = 1'b1;
        @(posedge clk);
    endtask

    // Checks cycles 1..last after an acceptance edge; last<=0 means through the done cycle F+1.
    task automatic watch(input int s, input logic [7:0] d, input bit hold, input logic [7:0] nd, input int last);
        int f = (2 + dw[s] + pe[s]) * cpb[s];
        int n = last > 0 ? last : f + 1;
        logic bits[$];
        logic p = 1'b0;
        bits.push_back(1'b0);
        for (int k = 0; k < dw[s]; k++) begin
            bits.push_back(d[k]);
            p ^= d[k];
        end
        if (pe[s] != 0) bits.push_back(p);
        bits.push_back(1'b1);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) valid[s] = 1'b0;
            if (c == 5 && hold) data[s] = nd;
            if (c <= f) begin
                check($sformatf("s%0d_d%0h_c%0d_out", s, d, c), 32'(out[s]), 32'(bits[(c - 1) / cpb[s]]));
                check($sformatf("s%0d_d%0h_c%0d_busy", s, d, c), 32'(busy[s]), 1);
                check($sformatf("s%0d_d%0h_c%0d_ready", s, d, c), 32'(ready[s]), 0);
                check($sformatf("s%0d_d%0h_c%0d_done", s, d, c), 32'(done[s]), 0);
            end else begin
                check($sformatf("s%0d_d%0h_end_out", s, d), 32'(out[s]), 1);
                check($sformatf("s%0d_d%0h_end_busy", s, d), 32'(busy[s]), 0);
                check($sformatf("s%0d_d%0h_end_ready", s, d), 32'(ready[s]), 1);
                check($sformatf("s%0d_d%0h_end_done", s, d), 32'(done[s]), 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        valid = '1;
        for (int s = 0; s < 3; s++) data[s] = 8'($urandom);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) idle_check(s, $sformatf("rst%0d", s));
        reset = 1'b0;
        valid = '0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) idle_check(s, $sformatf("post_rst%0d", s));

        start(0, 8'hA5);
        watch(0, 8'hA5, 1'b0, 8'h00, 0);
        @(negedge clk);
        check("a5_done_once", 32'(done[0]), 0);

        start(1, 8'h07);
        watch(1, 8'h07, 1'b0, 8'h00, 0);
        start(1, 8'h03);
        watch(1, 8'h03, 1'b0, 8'h00, 0);

        start(0, 8'h3C);
        watch(0, 8'h3C, 1'b1, 8'hFF, 0);
        watch(0, 8'hFF, 1'b0, 8'h00, 0);
        repeat (3) @(negedge clk);
        idle_check(0, "b2b_idle");

        start(0, 8'h55);
        watch(0, 8'h55, 1'b0, 8'h00, 18);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_check(0, "midrst");
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            check($sformatf("midrst_nodone%0d", c), 32'(done[0]), 0);
        end
        start(0, 8'h81);
        watch(0, 8'h81, 1'b0, 8'h00, 0);

        start(2, 8'h01);
        watch(2, 8'h01, 1'b0, 8'h00, 0);

        repeat (4) begin
            for (int s = 0; s < 3; s++) begin
                logic [7:0] d = 8'($urandom);
                start(s, d);
                watch(s, d, 1'b0, 8'h00, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
